// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared definitions for the bowling score tracker:
//   - state_t   : game state (PLAY while frames remain, OVER afterwards)
//   - SEG_0..9  : active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   - SEG_BLANK : all segments off
// ---------------------------------------------------------------------------
package score_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_digit.sv
// ---------------------------------------------------------------------------
// seg7_digit
// Combinational decimal digit to active-low seven-segment decoder.
// Values above 9 produce a blank digit.
// Ports:
//   value  in  4  digit value
//   seg    out 7  active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_digit
    import score_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bowling_score_tracker.sv
// ---------------------------------------------------------------------------
// bowling_score_tracker
// Frame/roll score keeper: counts pin-hit edges per roll, enforces the
// per-frame pin limit, sequences rolls and frames, accumulates the game
// total and drives DIGITS active-low seven-segment digits.
//
// Optional build macro:
//   HIT_SYNC_EN - pass hit through a two-flop synchroniser before the edge
//                 detector (adds two edges of hit-to-score latency).
//
// Ports:
//   CLOCK_50    in   1                 system clock (rising edge)
//   reset       in   1                 synchronous active-high reset
//   hit         in   1                 level pin-hit; each rising edge = 1 pin
//   roll_done   in   1                 single-cycle end-of-roll pulse
//   score       out  SCORE_W           running game total
//   frame       out  $clog2(FRAMES+1)  current frame (FRAMES when over)
//   roll        out  $clog2(ROLLS)     current roll within frame
//   frame_pins  out  $clog2(PINS+1)    pins down so far this frame
//   game_over   out  1                 high once all frames are played
//   HEX         out  7*DIGITS          active-low digits, HEX[6:0] = ones
// ---------------------------------------------------------------------------
module bowling_score_tracker
    import score_pkg::*;
#(
    parameter int PINS    = 10,
    parameter int FRAMES  = 3,
    parameter int ROLLS   = 2,
    parameter int SCORE_W = $clog2(PINS*FRAMES+1),
    parameter int DIGITS  = 2
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          hit,
    input  logic                          roll_done,
    output logic [SCORE_W-1:0]            score,
    output logic [$clog2(FRAMES+1)-1:0]   frame,
    output logic [$clog2(ROLLS)-1:0]      roll,
    output logic [$clog2(PINS+1)-1:0]     frame_pins,
    output logic                          game_over,
    output logic [7*DIGITS-1:0]           HEX
);

    localparam int FW = $clog2(FRAMES+1);
    localparam int RW = $clog2(ROLLS);
    localparam int PW = $clog2(PINS+1);

    localparam logic [PW-1:0] PINS_V       = PW'(PINS);
    localparam logic [RW-1:0] LAST_ROLL    = RW'(ROLLS-1);
    localparam logic [FW-1:0] LAST_FRAME   = FW'(FRAMES-1);
    localparam logic [FW-1:0] FRAMES_V     = FW'(FRAMES);

    // -------------------------------------------------------------------
    // Hit source: optionally synchronised
    // -------------------------------------------------------------------
    logic hit_src;

`ifdef HIT_SYNC_EN
    logic hit_s1_d, hit_s1_q;
    logic hit_s2_d, hit_s2_q;

    assign hit_s1_d = hit;
    assign hit_s2_d = hit_s1_q;
    assign hit_src  = hit_s2_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hit_s1_q <= 1'b0;
            hit_s2_q <= 1'b0;
        end else begin
            hit_s1_q <= hit_s1_d;
            hit_s2_q <= hit_s2_d;
        end
    end
`else
    assign hit_src = hit;
`endif

    // -------------------------------------------------------------------
    // Game state
    // -------------------------------------------------------------------
    state_t              state_d,     state_q;
    logic                hit_d,       hit_q;
    logic [SCORE_W-1:0]  score_d,     score_q;
    logic [FW-1:0]       frame_d,     frame_q;
    logic [RW-1:0]       roll_d,      roll_q;
    logic [PW-1:0]       pins_d,      pins_q;
    logic                game_over_d, game_over_q;
    logic [7*DIGITS-1:0] hex_d,       hex_q;

    logic                hit_edge;
    logic [PW-1:0]       pins_hit;    // frame pins including a hit this cycle

    assign hit_edge = hit_src & ~hit_q;

    always_comb begin
        state_d     = state_q;
        hit_d       = hit_src;
        score_d     = score_q;
        frame_d     = frame_q;
        roll_d      = roll_q;
        pins_d      = pins_q;
        game_over_d = game_over_q;
        pins_hit    = pins_q;

        if (state_q == PLAY) begin
            // Hits beyond the frame limit are dropped rather than wrapped.
            if (hit_edge && (pins_q < PINS_V)) begin
                pins_hit = pins_q + PW'(1);
                score_d  = score_q + SCORE_W'(1);
            end
            pins_d = pins_hit;

            // A hit arriving with roll_done belongs to the closing roll, so
            // the frame-full test looks at pins_hit.
            if (roll_done) begin
                if ((pins_hit == PINS_V) || (roll_q == LAST_ROLL)) begin
                    roll_d = '0;
                    pins_d = '0;
                    if (frame_q == LAST_FRAME) begin
                        frame_d     = FRAMES_V;
                        state_d     = OVER;
                        game_over_d = 1'b1;
                    end else begin
                        frame_d = frame_q + FW'(1);
                    end
                end else begin
                    roll_d = roll_q + RW'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------
    // Display: binary score to decimal digits, registered decode
    // -------------------------------------------------------------------
    logic [7*DIGITS-1:0] seg_w;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        localparam int unsigned P = 10**g;
        logic [3:0] dval;

        assign dval = 4'((32'(score_q) / P) % 32'd10);

        seg7_digit u_seg (
            .value (dval),
            .seg   (seg_w[7*g +: 7])
        );
    end

    assign hex_d = seg_w;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= PLAY;
            hit_q       <= 1'b0;
            score_q     <= '0;
            frame_q     <= '0;
            roll_q      <= '0;
            pins_q      <= '0;
            game_over_q <= 1'b0;
            hex_q       <= {DIGITS{SEG_0}};
        end else begin
            state_q     <= state_d;
            hit_q       <= hit_d;
            score_q     <= score_d;
            frame_q     <= frame_d;
            roll_q      <= roll_d;
            pins_q      <= pins_d;
            game_over_q <= game_over_d;
            hex_q       <= hex_d;
        end
    end

    assign score      = score_q;
    assign frame      = frame_q;
    assign roll       = roll_q;
    assign frame_pins = pins_q;
    assign game_over  = game_over_q;
    assign HEX        = hex_q;

endmodule

// File: tb/tb_bowling_score_tracker.sv
// ---------------------------------------------------------------------------
// tb_bowling_score_tracker
// Directed-vector bench for bowling_score_tracker (default parameters).
// ---------------------------------------------------------------------------
module tb_bowling_score_tracker;

`ifdef HIT_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT = 1 + EXTRA;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S7 = 7'b1111000;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        hit = 1'b0;
    logic        roll_done = 1'b0;
    logic [4:0]  score;
    logic [1:0]  frame;
    logic [0:0]  roll;
    logic [3:0]  frame_pins;
    logic        game_over;
    logic [13:0] HEX;

    int checks = 0;
    int failures = 0;

    bowling_score_tracker dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .hit        (hit),
        .roll_done  (roll_done),
        .score      (score),
        .frame      (frame),
        .roll       (roll),
        .frame_pins (frame_pins),
        .game_over  (game_over),
        .HEX        (HEX)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic settle();
        repeat (EXTRA) tick();
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            hit = 1'b1;
            tick();
            hit = 1'b0;
            tick();
        end
        settle();
    endtask

    task automatic end_roll();
        roll_done = 1'b1;
        tick();
        roll_done = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int lat;

        // Reset values
        do_reset();
        check("rst_score", 32'(score), 0);
        check("rst_frame", 32'(frame), 0);
        check("rst_roll", 32'(roll), 0);
        check("rst_pins", 32'(frame_pins), 0);
        check("rst_over", 32'(game_over), 0);
        check("rst_hex", 32'(HEX), 32'({S0, S0}));

        // Four pins then end of roll 0
        pulse(4);
        end_roll();
        check("r0_score", 32'(score), 4);
        check("r0_pins", 32'(frame_pins), 4);
        check("r0_roll", 32'(roll), 1);
        check("r0_frame", 32'(frame), 0);
        check("r0_hex_ones", 32'(HEX[6:0]), 32'(S4));
        check("r0_hex_tens", 32'(HEX[13:7]), 32'(S0));

        // Level-held hit counts once
        hit = 1'b1;
        repeat (20) tick();
        hit = 1'b0;
        tick();
        settle();
        check("held_score", 32'(score), 5);
        check("held_pins", 32'(frame_pins), 5);

        // Hit edge coincident with roll_done on roll 1
        hit = 1'b1;
        settle();
        roll_done = 1'b1;
        tick();
        roll_done = 1'b0;
        hit = 1'b0;
        tick();
        settle();
        check("coin_score", 32'(score), 6);
        check("coin_frame", 32'(frame), 1);
        check("coin_roll", 32'(roll), 0);
        check("coin_pins", 32'(frame_pins), 0);

        // Build up to 17 mid-frame, then reset with active inputs
        pulse(10);
        end_roll();
        pulse(1);
        tick();
        check("mid_score", 32'(score), 17);
        check("mid_frame", 32'(frame), 2);
        check("mid_hex", 32'(HEX), 32'({S1, S7}));
        reset = 1'b1;
        hit = 1'b1;
        roll_done = 1'b1;
        tick();
        roll_done = 1'b0;
        check("mrst_score", 32'(score), 0);
        check("mrst_frame", 32'(frame), 0);
        check("mrst_roll", 32'(roll), 0);
        check("mrst_pins", 32'(frame_pins), 0);
        check("mrst_over", 32'(game_over), 0);
        check("mrst_hex", 32'(HEX), 32'({S0, S0}));

        // Hit held through reset counts once after release; measure latency
        tick();
        reset = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (score == 5'd1) begin
                lat = k;
                break;
            end
        end
        check("hit_latency", 32'(lat), 32'(LAT));
        repeat (5) tick();
        hit = 1'b0;
        tick();
        check("post_rst_score", 32'(score), 1);

        // Strike frame: extra pins ignored, roll_done after roll 0 ends frame
        do_reset();
        pulse(12);
        check("strike_pins", 32'(frame_pins), 10);
        check("strike_score", 32'(score), 10);
        end_roll();
        check("strike_frame", 32'(frame), 1);
        check("strike_roll", 32'(roll), 0);
        check("strike_pins0", 32'(frame_pins), 0);

        // Finish the game with two more full frames
        pulse(10);
        end_roll();
        pulse(10);
        end_roll();
        check("over_score", 32'(score), 30);
        check("over_flag", 32'(game_over), 1);
        check("over_frame", 32'(frame), 3);
        check("over_hex_tens", 32'(HEX[13:7]), 32'(S3));
        check("over_hex_ones", 32'(HEX[6:0]), 32'(S0));

        // Inputs ignored while over
        pulse(3);
        end_roll();
        check("hold_score", 32'(score), 30);
        check("hold_frame", 32'(frame), 3);
        check("hold_over", 32'(game_over), 1);

        do_reset();
        check("final_over", 32'(game_over), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
